// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding, stage
// indices, load/clear patterns and counter widths.
package pipe_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StMcWait,
    StDrain,
    StHalt
  } state_e;

  // Bit index of each stage register within the ld/clr vectors
  localparam int unsigned IF_ID  = 0;
  localparam int unsigned ID_EX  = 1;
  localparam int unsigned EX_MEM = 2;
  localparam int unsigned MEM_WB = 3;

  localparam logic [3:0] BIT_IF_ID  = 4'(1 << IF_ID);
  localparam logic [3:0] BIT_ID_EX  = 4'(1 << ID_EX);
  localparam logic [3:0] BIT_EX_MEM = 4'(1 << EX_MEM);
  localparam logic [3:0] BIT_MEM_WB = 4'(1 << MEM_WB);

  // Load-enable patterns
  localparam logic [3:0] LD_NONE   = 4'b0000;
  localparam logic [3:0] LD_ALL    = BIT_IF_ID | BIT_ID_EX | BIT_EX_MEM | BIT_MEM_WB;
  localparam logic [3:0] LD_BUBBLE = LD_ALL & ~BIT_IF_ID;  // IF/ID holds on load-use
  localparam logic [3:0] LD_WB     = BIT_MEM_WB;

  // Clear patterns
  localparam logic [3:0] CLR_NONE  = 4'b0000;
  localparam logic [3:0] CLR_ALL   = LD_ALL;
  localparam logic [3:0] CLR_FLUSH = BIT_IF_ID | BIT_ID_EX;
  localparam logic [3:0] CLR_IDEX  = BIT_ID_EX;
  localparam logic [3:0] CLR_IFID  = BIT_IF_ID;
  localparam logic [3:0] CLR_WB    = BIT_MEM_WB;

  // Counter widths: timeout reaches at most 62, drain at most 6
  localparam int unsigned TO_W    = 6;
  localparam int unsigned DR_W    = 3;
  localparam int unsigned STALL_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over inc.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;

  // Count up on inc, hold at all-ones instead of wrapping
  always_ff @(posedge clock) begin
    if (clear) begin
      value_q <= '0;
    end else if (inc && (value_q != '1)) begin
      value_q <= value_q + WIDTH'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: PC/stage-register load and clear sequencing
// for hazards, multicycle ops and halt draining.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT   = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        halt_req,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        mem_wait,
  input  logic        mc_start,
  input  logic        mc_done,
  output logic        pc_ld,
  output logic [3:0]  ld,
  output logic [3:0]  clr,
  output logic        halted,
  output logic        err,
  output logic [31:0] stall_cnt
);

  state_e state_q, state_d;
  logic   err_q, err_set;

  logic            to_inc, to_load;
  logic            dr_inc, dr_load;
  logic [TO_W-1:0] to_cnt;
  logic [DR_W-1:0] dr_cnt;

  sat_counter #(.WIDTH(TO_W)) u_timeout (
    .clock (clock),
    .clear (clear | to_load),
    .inc   (to_inc),
    .value (to_cnt)
  );

  sat_counter #(.WIDTH(DR_W)) u_drain (
    .clock (clock),
    .clear (clear | dr_load),
    .inc   (dr_inc),
    .value (dr_cnt)
  );

  // State register and sticky timeout flag
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state, stage control outputs and counter controls
  always_comb begin
    state_d = state_q;
    pc_ld   = 1'b0;
    ld      = LD_NONE;
    clr     = CLR_NONE;
    halted  = 1'b0;
    to_inc  = 1'b0;
    to_load = 1'b0;
    dr_inc  = 1'b0;
    dr_load = 1'b0;
    err_set = 1'b0;
    if (clear) begin
      clr = CLR_ALL;
    end else begin
      unique case (state_q)
        StIdle: begin
          clr = CLR_ALL;
          if (start) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (mem_wait) begin
            // Full freeze, defaults already hold everything
          end else if (mc_start) begin
            to_load = 1'b1;
            state_d = StMcWait;
          end else if (branch_taken) begin
            pc_ld = 1'b1;
            ld    = LD_ALL;
            clr   = CLR_FLUSH;
          end else if (load_use) begin
            ld  = LD_BUBBLE;
            clr = CLR_IDEX;
          end else if (halt_req) begin
            ld      = LD_ALL;
            clr     = CLR_IFID;
            dr_load = 1'b1;
            state_d = StDrain;
          end else begin
            pc_ld = 1'b1;
            ld    = LD_ALL;
          end
        end
        StMcWait: begin
          if (mc_done) begin
            pc_ld   = 1'b1;
            ld      = LD_ALL;
            state_d = StRun;
          end else begin
            ld     = LD_WB;
            clr    = CLR_WB;
            to_inc = 1'b1;
            if (to_cnt == TO_W'(MC_TIMEOUT - 1)) begin
              err_set = 1'b1;
              state_d = StHalt;
            end
          end
        end
        StDrain: begin
          if (!mem_wait) begin
            ld     = LD_ALL;
            clr    = CLR_IFID;
            dr_inc = 1'b1;
            if (dr_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
              state_d = StHalt;
            end
          end
        end
        StHalt: begin
          halted = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign err = err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;

  // A stall is any RUN/MCWAIT cycle in which the PC does not advance
  always_comb begin
    stall_inc = ((state_q == StRun) || (state_q == StMcWait)) && !pc_ld;
  end

  sat_counter #(.WIDTH(STALL_W)) u_stall (
    .clock (clock),
    .clear (clear),
    .inc   (stall_inc),
    .value (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed table, hand-written multicycle
// sequence on a default-parameter instance, and randomized run against a model.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int MC_TO = 4;
  localparam int DRAIN = 3;

  typedef struct packed {
    logic clear;
    logic start;
    logic halt_req;
    logic load_use;
    logic branch_taken;
    logic mem_wait;
    logic mc_start;
    logic mc_done;
  } in_t;

  typedef struct {
    in_t        in;
    logic       pc_ld;
    logic [3:0] ld;
    logic [3:0] clr;
    logic       halted;
    logic       err;
    bit         chk_err;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  in_t in_s = '0;

  logic        pc_ld, halted, err;
  logic [3:0]  ld, clr;
  logic [31:0] stall_cnt;
  logic        pc_ld2, halted2, err2;
  logic [3:0]  ld2, clr2;
  logic [31:0] stall_cnt2;

  pipe_ctrl #(.MC_TIMEOUT(MC_TO), .DRAIN_CYCLES(DRAIN)) u_dut (
    .clock        (clock),
    .clear        (in_s.clear),
    .start        (in_s.start),
    .halt_req     (in_s.halt_req),
    .load_use     (in_s.load_use),
    .branch_taken (in_s.branch_taken),
    .mem_wait     (in_s.mem_wait),
    .mc_start     (in_s.mc_start),
    .mc_done      (in_s.mc_done),
    .pc_ld        (pc_ld),
    .ld           (ld),
    .clr          (clr),
    .halted       (halted),
    .err          (err),
    .stall_cnt    (stall_cnt)
  );

  pipe_ctrl u_dut2 (
    .clock        (clock),
    .clear        (in_s.clear),
    .start        (in_s.start),
    .halt_req     (in_s.halt_req),
    .load_use     (in_s.load_use),
    .branch_taken (in_s.branch_taken),
    .mem_wait     (in_s.mem_wait),
    .mc_start     (in_s.mc_start),
    .mc_done      (in_s.mc_done),
    .pc_ld        (pc_ld2),
    .ld           (ld2),
    .clr          (clr2),
    .halted       (halted2),
    .err          (err2),
    .stall_cnt    (stall_cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- Reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_MCWAIT = 2, M_DRAIN = 3, M_HALT = 4;
  int     m_mode = M_IDLE;
  int     m_mc_elapsed = 0;  // MCWAIT cycles already spent without mc_done
  int     m_drained = 0;     // productive DRAIN cycles already spent
  bit     m_err = 1'b0;
  longint m_stalls = 0;

  // Returns {pc_ld, ld, clr, halted}
  function automatic logic [9:0] model_out(input in_t i);
    if (i.clear) return {1'b0, 4'b0000, 4'b1111, 1'b0};
    case (m_mode)
      M_IDLE: return {1'b0, 4'b0000, 4'b1111, 1'b0};
      M_RUN: begin
        if (i.mem_wait || i.mc_start) return {1'b0, 4'b0000, 4'b0000, 1'b0};
        if (i.branch_taken)          return {1'b1, 4'b1111, 4'b0011, 1'b0};
        if (i.load_use)              return {1'b0, 4'b1110, 4'b0010, 1'b0};
        if (i.halt_req)              return {1'b0, 4'b1111, 4'b0001, 1'b0};
        return {1'b1, 4'b1111, 4'b0000, 1'b0};
      end
      M_MCWAIT: return i.mc_done ? {1'b1, 4'b1111, 4'b0000, 1'b0}
                                 : {1'b0, 4'b1000, 4'b1000, 1'b0};
      M_DRAIN: return i.mem_wait ? {1'b0, 4'b0000, 4'b0000, 1'b0}
                                 : {1'b0, 4'b1111, 4'b0001, 1'b0};
      default: return {1'b0, 4'b0000, 4'b0000, 1'b1};
    endcase
  endfunction

  task automatic model_advance(input in_t i);
    logic [9:0] o;
    if (i.clear) begin
      m_mode = M_IDLE; m_mc_elapsed = 0; m_drained = 0; m_err = 1'b0; m_stalls = 0;
      return;
    end
    o = model_out(i);
    if (PERF && (m_mode == M_RUN || m_mode == M_MCWAIT) && !o[9] && m_stalls < 64'hFFFF_FFFF)
      m_stalls++;
    case (m_mode)
      M_IDLE: if (i.start) m_mode = M_RUN;
      M_RUN: begin
        if (i.mem_wait) begin
        end else if (i.mc_start) begin
          m_mode = M_MCWAIT; m_mc_elapsed = 0;
        end else if (!i.branch_taken && !i.load_use && i.halt_req) begin
          m_mode = M_DRAIN; m_drained = 0;
        end
      end
      M_MCWAIT: begin
        if (i.mc_done) m_mode = M_RUN;
        else begin
          m_mc_elapsed++;
          if (m_mc_elapsed == MC_TO) begin
            m_err = 1'b1; m_mode = M_HALT;
          end
        end
      end
      M_DRAIN: if (!i.mem_wait) begin
        m_drained++;
        if (m_drained == DRAIN) m_mode = M_HALT;
      end
      default: ;
    endcase
  endtask

  // ---------------- Directed table ----------------
  vec_t tbl[$];

  function automatic in_t mk(input bit c, s, h, lu, b, mw, ms, md);
    in_t r;
    r = '{clear: c, start: s, halt_req: h, load_use: lu, branch_taken: b,
          mem_wait: mw, mc_start: ms, mc_done: md};
    return r;
  endfunction

  task automatic add(input in_t i, input logic p, input logic [3:0] l, input logic [3:0] c,
                     input logic h, input logic e, input bit ce);
    vec_t v;
    v = '{in: i, pc_ld: p, ld: l, clr: c, halted: h, err: e, chk_err: ce};
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_t idle;
    in_t mcw;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    mcw  = idle;

    // Initial reset of both instances and the model
    in_s = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    model_advance(in_s);

    add(mk(1, 0, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b1111, 0, 0, 1);
    add(idle,                       0, 4'b0000, 4'b1111, 0, 0, 1);
    add(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b1111, 0, 0, 1);
    add(idle,                       1, 4'b1111, 4'b0000, 0, 0, 1);
    add(mk(0, 0, 0, 1, 1, 0, 0, 0), 1, 4'b1111, 4'b0011, 0, 0, 1);
    add(mk(0, 0, 0, 1, 0, 0, 0, 0), 0, 4'b1110, 4'b0010, 0, 0, 1);
    add(mk(0, 0, 0, 0, 1, 1, 1, 0), 0, 4'b0000, 4'b0000, 0, 0, 1);
    add(mk(0, 0, 1, 1, 0, 0, 0, 0), 0, 4'b1110, 4'b0010, 0, 0, 1);
    add(mk(0, 1, 0, 0, 0, 0, 0, 0), 1, 4'b1111, 4'b0000, 0, 0, 1);
    add(mk(0, 0, 0, 0, 0, 0, 1, 0), 0, 4'b0000, 4'b0000, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(mcw, 0, 4'b1000, 4'b1000, 0, 0, 1);
    add(mk(0, 0, 0, 0, 0, 0, 0, 1), 1, 4'b1111, 4'b0000, 0, 0, 1);
    add(mk(0, 0, 0, 0, 0, 0, 1, 0), 0, 4'b0000, 4'b0000, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(mcw, 0, 4'b1000, 4'b1000, 0, 0, 1);
    // mc_done on the final permitted cycle beats the timeout
    add(mk(0, 0, 0, 0, 0, 0, 0, 1), 1, 4'b1111, 4'b0000, 0, 0, 1);
    // Halt with mem_wait stretching DRAIN: halted six cycles later
    add(mk(0, 0, 1, 0, 0, 0, 0, 0), 0, 4'b1111, 4'b0001, 0, 0, 1);
    add(mk(0, 1, 0, 1, 1, 0, 0, 0), 0, 4'b1111, 4'b0001, 0, 0, 1);
    add(mk(0, 0, 0, 0, 0, 1, 0, 0), 0, 4'b0000, 4'b0000, 0, 0, 1);
    add(mk(0, 0, 0, 0, 0, 1, 0, 0), 0, 4'b0000, 4'b0000, 0, 0, 1);
    add(idle,                       0, 4'b1111, 4'b0001, 0, 0, 1);
    add(idle,                       0, 4'b1111, 4'b0001, 0, 0, 1);
    add(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b0000, 1, 0, 1);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b1111, 0, 0, 1);
    // Timeout: four MCWAIT cycles then HALT with err
    add(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b1111, 0, 0, 1);
    add(mk(0, 0, 0, 0, 0, 0, 1, 0), 0, 4'b0000, 4'b0000, 0, 0, 1);
    for (int k = 0; k < 4; k++) add(mcw, 0, 4'b1000, 4'b1000, 0, 0, 1);
    add(idle,                       0, 4'b0000, 4'b0000, 1, 1, 1);
    add(mk(0, 1, 0, 0, 0, 0, 1, 1), 0, 4'b0000, 4'b0000, 1, 1, 1);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b1111, 0, 0, 0);
    add(idle,                       0, 4'b0000, 4'b1111, 0, 0, 1);
    // clear in the second MCWAIT cycle
    add(mk(0, 1, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b1111, 0, 0, 1);
    add(mk(0, 0, 0, 0, 0, 0, 1, 0), 0, 4'b0000, 4'b0000, 0, 0, 1);
    add(mcw,                        0, 4'b1000, 4'b1000, 0, 0, 1);
    add(mk(1, 0, 0, 0, 0, 0, 0, 0), 0, 4'b0000, 4'b1111, 0, 0, 0);
    add(idle,                       0, 4'b0000, 4'b1111, 0, 0, 1);

    foreach (tbl[k]) begin
      in_s = tbl[k].in;
      #1;
      check($sformatf("tbl%0d_out", k), {54'd0, pc_ld, ld, clr, halted},
            {54'd0, tbl[k].pc_ld, tbl[k].ld, tbl[k].clr, tbl[k].halted});
      if (tbl[k].chk_err) check($sformatf("tbl%0d_err", k), {63'd0, err}, {63'd0, tbl[k].err});
      check($sformatf("tbl%0d_stall", k), {32'd0, stall_cnt}, m_stalls);
      model_advance(in_s);
      tick();
    end

    // Default-parameter instance: five MCWAIT cycles then mc_done
    in_s = mk(1, 0, 0, 0, 0, 0, 0, 0); tick();
    in_s = mk(0, 1, 0, 0, 0, 0, 0, 0); tick();
    in_s = mk(0, 0, 0, 0, 0, 0, 1, 0); #1;
    check("mc5_issue", {58'd0, pc_ld2, ld2, clr2[0]}, 64'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      in_s = idle; #1;
      check($sformatf("mc5_wait%0d", k), {55'd0, pc_ld2, ld2, clr2}, {55'd0, 1'b0, 4'b1000, 4'b1000});
      tick();
    end
    in_s = mk(0, 0, 0, 0, 0, 0, 0, 1); #1;
    check("mc5_done", {55'd0, pc_ld2, ld2, clr2}, {55'd0, 1'b1, 4'b1111, 4'b0000});
    tick();
    in_s = idle; #1;
    check("mc5_stall", {32'd0, stall_cnt2}, PERF ? 64'd6 : 64'd0);
    check("mc5_err", {63'd0, err2}, 64'd0);
    tick();

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      in_t r;
      logic [9:0] e;
      r.clear        = (c == 0) || ($urandom_range(99) < 3);
      r.start        = $urandom_range(99) < 20;
      r.halt_req     = $urandom_range(99) < 6;
      r.load_use     = $urandom_range(99) < 15;
      r.branch_taken = $urandom_range(99) < 15;
      r.mem_wait     = $urandom_range(99) < 15;
      r.mc_start     = $urandom_range(99) < 10;
      r.mc_done      = $urandom_range(99) < 25;
      in_s = r;
      #1;
      if (c > 0) begin
        e = model_out(r);
        check($sformatf("rnd%0d_out", c), {54'd0, pc_ld, ld, clr, halted}, {54'd0, e});
        check($sformatf("rnd%0d_err_stall", c), {31'd0, err, stall_cnt}, {31'd0, m_err, m_stalls[31:0]});
      end
      model_advance(r);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
